// File: rtl/mem_arbiter.sv
// Shares one single-port memory among fetch (i), data (d) and external (x) requesters, one access at a time.
// Build option: define ARB_FIXED_PRIO_EN for fixed d > x > i priority instead of rotating priority.
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  input  logic          x_req,
  input  logic          x_we,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wdata,
  output logic          x_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam int NP = 3;
  localparam int CW = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t        state;
  logic [1:0]    last_grant;
  logic [1:0]    grant_q;
  logic [CW-1:0] cnt;
  logic [NP-1:0] ack_q;
  logic [NP-1:0] req_vec;
  req_t [NP-1:0] req_info;
  logic          win_vld;
  logic [1:0]    win;
  req_t          win_req;

  assign req_vec     = {x_req, d_req, i_req};
  assign req_info[0] = {1'b0, i_addr, {DW{1'b0}}};
  assign req_info[1] = {d_we, d_addr, d_wdata};
  assign req_info[2] = {x_we, x_addr, x_wdata};

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win_vld = |req_vec;
    win     = 2'd0;
    if (d_req)      win = 2'd1;
    else if (x_req) win = 2'd2;
  end
`else
  // Search starts one past the previous winner, wrapping i -> d -> x -> i.
  always_comb begin
    logic [1:0] p;
    win_vld = 1'b0;
    win     = 2'd0;
    p       = last_grant;
    for (int k = 0; k < NP; k++) begin
      p = (p == 2'd2) ? 2'd0 : p + 2'd1;
      if (req_vec[p] && !win_vld) begin
        win_vld = 1'b1;
        win     = p;
      end
    end
  end
`endif

  assign win_req = req_info[win];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 2'd2;
      grant_q    <= 2'd0;
      cnt        <= '0;
      ack_q      <= '0;
      rdata      <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      ack_q  <= '0;
      mem_en <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant_q    <= win;
            last_grant <= win;
            mem_we     <= win_req.we;
            mem_addr   <= win_req.addr;
            mem_wdata  <= win_req.wdata;
            mem_en     <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_we) begin
            ack_q <= 3'b001 << grant_q;
            state <= DONE;
          end else if (MEM_LAT == 1) begin
            rdata <= mem_rdata;
            ack_q <= 3'b001 << grant_q;
            state <= DONE;
          end else begin
            cnt   <= CW'(MEM_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          // Count of 1 marks the cycle the memory output is valid.
          if (cnt == CW'(1)) begin
            rdata <= mem_rdata;
            ack_q <= 3'b001 << grant_q;
            state <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign i_ack = ack_q[0];
  assign d_ack = ack_q[1];
  assign x_ack = ack_q[2];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: MEM_LAT=1 and MEM_LAT=4 instances, directed cases then random traffic
// checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input int lat, input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL L%0d %s actual=%0h required=%0h", lat, nm, act, req);
    end
  endtask

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : h
    localparam int LAT = (g == 0) ? 1 : 4;

    logic        reset = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, x_req = 1'b0, x_we = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0, x_addr = '0, x_wdata = '0;
    logic        i_ack, d_ack, x_ack, mem_en, mem_we, busy;
    logic [15:0] rdata, mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [2:0]  acks;
    bit          done_f = 1'b0;

    assign acks = {x_ack, d_ack, i_ack};

    mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT)) dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
      .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata), .x_ack(x_ack),
      .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory stand-in: a read issued in cycle c is presented only during cycle c+LAT-1, junk otherwise.
    logic [15:0] ram [logic [15:0]];
    logic [15:0] rd_pipe [8];
    bit          rv_pipe [8];

    function automatic logic [15:0] ram_rd(input logic [15:0] a);
      return ram.exists(a) ? ram[a] : init_word(a);
    endfunction

    always @(posedge clock) begin
      #2;
      for (int k = 7; k > 0; k--) begin
        rd_pipe[k] = rd_pipe[k-1];
        rv_pipe[k] = rv_pipe[k-1];
      end
      rv_pipe[0] = mem_en && !mem_we;
      rd_pipe[0] = ram_rd(mem_addr);
      if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
      mem_rdata = rv_pipe[LAT-1] ? rd_pipe[LAT-1] : 16'($urandom);
    end

    // Transaction-level model: one record per grant, outputs derived from the grant cycle and latency.
    logic [15:0] mmem [logic [15:0]];
    bit          m_act = 1'b0;
    bit          m_we = 1'b0;
    int          m_port = 0, m_start = 0, m_len = 0, m_last = 2;
    logic [15:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [2:0]  prev_ack = '0;

    function automatic logic [15:0] mmem_rd(input logic [15:0] a);
      return mmem.exists(a) ? mmem[a] : init_word(a);
    endfunction

    always @(negedge clock) begin
      int age, p, c;
      logic [2:0] reqs, e_ack;
      logic e_busy, e_en;
      age      = cyc - m_start;
      prev_ack = acks;
      if (reset) begin
        m_act = 1'b0; m_last = 2; m_rdata = '0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        chk(LAT, "reset_outputs",
            {busy, mem_en, mem_we, acks, mem_addr, mem_wdata, rdata}, 64'd0);
      end else begin
        e_busy = m_act && age >= 1 && age <= m_len;
        e_en   = m_act && age == 1;
        e_ack  = (m_act && age == m_len) ? (3'b001 << m_port) : 3'b000;
        if (e_ack != 3'b000 && !m_we) m_rdata = mmem_rd(m_addr);
        chk(LAT, "cycle_outputs",
            {busy, mem_en, mem_we, acks, mem_addr, mem_wdata, rdata},
            {e_busy, e_en, m_we, e_ack, m_addr, m_wdata, m_rdata});
        if (e_en && m_we) mmem[m_addr] = m_wdata;
        if (m_act && age > m_len) m_act = 1'b0;
        reqs = {x_req, d_req, i_req};
        if (!m_act && reqs != 3'b000) begin
          p = -1;
`ifdef ARB_FIXED_PRIO_EN
          p = reqs[1] ? 1 : (reqs[2] ? 2 : 0);
`else
          for (int k = 1; k <= 3; k++) begin
            c = (m_last + k) % 3;
            if (p < 0 && reqs[c]) p = c;
          end
`endif
          if (p == 0) begin
            m_we = 1'b0; m_addr = i_addr; m_wdata = '0;
          end else if (p == 1) begin
            m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
          end else begin
            m_we = x_we; m_addr = x_addr; m_wdata = x_wdata;
          end
          m_act = 1'b1; m_port = p; m_last = p; m_start = cyc;
          m_len = m_we ? 2 : 1 + LAT;
        end
      end
    end

    task automatic tick();
      @(posedge clock);
      #1;
    endtask

    task automatic wait_ack(input int port, output int at);
      at = -1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clock);
        if (acks[port]) begin
          at = cyc;
          break;
        end
      end
      chk(LAT, "ack_seen", 64'(at >= 0), 64'd1);
    endtask

    function automatic logic [15:0] rand_addr();
      return ($urandom_range(0, 1) ? 16'h7FF0 : 16'h0200) | 16'($urandom_range(0, 15));
    endfunction

    initial begin
      int t0, at;
      logic [2:0] seen [$];
      logic [2:0] first;
      ram[16'h0010]  = 16'hABCD; mmem[16'h0010] = 16'hABCD;
      ram[16'h7FFF]  = 16'hBEEF; mmem[16'h7FFF] = 16'hBEEF;
      tick();
      chk(LAT, "reset_state", {busy, mem_en, mem_we, acks, mem_addr, mem_wdata, rdata}, 64'd0);
      tick();
      reset = 1'b0;
      tick();

      // fetch read
      i_addr = 16'h0010; i_req = 1'b1; t0 = cyc;
      @(negedge clock); @(negedge clock);
      chk(LAT, "i_issue", {mem_en, mem_we, mem_addr, busy}, {1'b1, 1'b0, 16'h0010, 1'b1});
      wait_ack(0, at);
      chk(LAT, "i_latency", 64'(at - t0), 64'(1 + LAT));
      chk(LAT, "i_rdata", rdata, 16'hABCD);

      // data write
      tick();
      i_req = 1'b0;
      d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234; d_req = 1'b1; t0 = cyc;
      @(negedge clock); @(negedge clock);
      chk(LAT, "d_issue", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 16'h0200, 16'h1234});
      wait_ack(1, at);
      chk(LAT, "d_latency", 64'(at - t0), 64'd2);
      chk(LAT, "d_rdata_held", rdata, 16'hABCD);

      // external read; fields change after the grant edge
      tick();
      d_req = 1'b0; d_we = 1'b0;
      x_we = 1'b0; x_addr = 16'h7FFF; x_req = 1'b1; t0 = cyc;
      tick();
      x_addr = 16'h1111; x_we = 1'b1; x_wdata = 16'h5555;
      wait_ack(2, at);
      chk(LAT, "x_latency", 64'(at - t0), 64'(1 + LAT));
      chk(LAT, "x_rdata", rdata, 16'hBEEF);
      chk(LAT, "x_addr_held", mem_addr, 16'h7FFF);

      // all three requesting from reset: strict rotation i, d, x
      tick();
      x_req = 1'b0; x_we = 1'b0;
      reset = 1'b1;
      tick();
      i_addr = 16'h0010; d_addr = 16'h0200; x_addr = 16'h7FFF;
      i_req = 1'b1; d_req = 1'b1; x_req = 1'b1;
      tick();
      reset = 1'b0;
      seen.delete();
      for (int k = 0; k < 60 && seen.size() < 6; k++) begin
        @(negedge clock);
        if (acks != 3'b000) seen.push_back(acks);
      end
      chk(LAT, "rot_count", 64'(seen.size()), 64'd6);
      for (int k = 0; k < seen.size(); k++)
        chk(LAT, $sformatf("rot_order_%0d", k), seen[k], 3'b001 << (k % 3));

      // reset in the middle of a data read, then i and d contend
      tick();
      i_req = 1'b0; d_req = 1'b0; x_req = 1'b0;
      tick();
      d_we = 1'b0; d_addr = 16'h0033; d_req = 1'b1;
      repeat (LAT == 1 ? 1 : 2) tick();
      reset = 1'b1;
      @(negedge clock);
      chk(LAT, "reset_mid", {busy, mem_en, mem_we, acks, mem_addr, mem_wdata, rdata}, 64'd0);
      tick();
      reset = 1'b0; i_addr = 16'h0010; i_req = 1'b1;
      first = 3'b000;
      for (int k = 0; k < 20 && first == 3'b000; k++) begin
        @(negedge clock);
        first = acks;
      end
      chk(LAT, "post_reset_first", first, 3'b001);
      tick();
      i_req = 1'b0;
      wait_ack(1, at);
      tick();
      d_req = 1'b0;

      // random traffic
      for (int n = 0; n < 1500; n++) begin
        tick();
        if (prev_ack[0]) i_req = 1'b0;
        if (prev_ack[1]) d_req = 1'b0;
        if (prev_ack[2]) x_req = 1'b0;
        if (reset) reset = 1'b0;
        else if ($urandom_range(0, 299) == 0) reset = 1'b1;
        if (!i_req && $urandom_range(0, 2) == 0) begin
          i_addr = rand_addr(); i_req = 1'b1;
        end
        if (!d_req && $urandom_range(0, 2) == 0) begin
          d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr(); d_wdata = 16'($urandom); d_req = 1'b1;
        end
        if (!x_req && $urandom_range(0, 2) == 0) begin
          x_we = 1'($urandom_range(0, 1)); x_addr = rand_addr(); x_wdata = 16'($urandom); x_req = 1'b1;
        end
        // disturb the in-flight requester's fields; the latched values must not move
        if (m_act && cyc > m_start && cyc - m_start <= m_len && $urandom_range(0, 1) == 1) begin
          if (m_port == 0) i_addr = 16'($urandom);
          else if (m_port == 1) begin d_addr = 16'($urandom); d_wdata = 16'($urandom); d_we = ~d_we; end
          else begin x_addr = 16'($urandom); x_wdata = 16'($urandom); x_we = ~x_we; end
        end
      end
      tick();
      i_req = 1'b0; d_req = 1'b0; x_req = 1'b0; reset = 1'b0;
      repeat (20) tick();
      done_f = 1'b1;
    end
  end

  initial begin
    for (int k = 0; k < 20000 && !(h[0].done_f && h[1].done_f); k++) @(posedge clock);
    chk(0, "bench_completed", 64'(h[0].done_f && h[1].done_f), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port 16-bit memory among three requesters: instruction fetch (i), CPU data (d) and an external loader/DMA port (x).
- Sits between the multicycle LEGLite core and the unified memory.
- Arbitrates with rotating priority and sequences one memory transaction at a time.
- Returns read data and a one-cycle ack to the winning requester.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..8.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- i_req  in  1  fetch read request; held until i_ack.
- i_addr  in  AW  fetch address.
- i_ack  out  1  one-cycle pulse; rdata valid this cycle.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  data write value.
- d_ack  out  1  one-cycle completion pulse.
- x_req  in  1  external request; held until x_ack.
- x_we  in  1  1 = write, 0 = read.
- x_addr  in  AW  external address.
- x_wdata  in  DW  external write value.
- x_ack  out  1  one-cycle completion pulse.
- rdata  out  DW  shared read-return bus, registered.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset forces state=IDLE, last_grant=2 (x), cycle counter=0, and all outputs to 0, including acks, mem_en, mem_we, mem_addr, mem_wdata and rdata.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise pick the winner by rotating priority starting at last_grant+1 (mod 3); port order is i=0, d=1, x=2.
  - At the clock edge: latch winner, we (i forces we=0), addr and wdata into mem_* registers; set last_grant=winner; go to ISSUE.
- ISSUE (1 cycle):
  - mem_en=1; mem_we=latched we.
  - Write: go to DONE.
  - Read: load counter=MEM_LAT-1.
    - If MEM_LAT=1, capture mem_rdata at the next edge and go to DONE.
    - Otherwise go to WAIT.
- WAIT:
  - mem_en=0; counter decrements each cycle.
  - On the edge where counter reaches 1, capture mem_rdata into rdata and go to DONE.
  - mem_rdata is therefore sampled exactly MEM_LAT cycles after the ISSUE cycle.
- DONE (1 cycle):
  - Winner's ack=1; other acks=0; rdata holds the read value, or is unchanged after a write.
  - No arbitration happens in DONE; go to IDLE.
  - A requester sees ack, and its deasserted or new req is first sampled in the following IDLE cycle.
- Latency, req first seen in IDLE at cycle t:
  - write: ack at t+2.
  - read: ack at t+1+MEM_LAT.
  - Back-to-back throughput: one transaction per 3+(read ? MEM_LAT-1 : 0) cycles.
- Address, we and wdata are sampled only at the grant edge; changes after grant have no effect.
- Dropping req before ack is illegal: the transaction still completes and the ack still pulses.
- Simultaneous requests are resolved purely by the rotation; a persistently requesting port waits at most two other transactions.
- mem_addr, mem_we and mem_wdata hold their latched values until the next grant; mem_en is the only access qualifier.
- Reset mid-transaction: abandoned immediately, no ack issued, last_grant returns to 2.
- rdata is never cleared except by reset.

Optional Feature:
- ARB_FIXED_PRIO_EN defined: fixed priority d > x > i replaces rotation; last_grant is unused and timing is unchanged.
- Undefined: rotating priority as above.

Test Plan:
- Reset then i_req=1, i_addr=0x0010, MEM_LAT=1, memory returns 0xABCD -> mem_en pulse with mem_addr=0x0010 and mem_we=0; i_ack at t+2 with rdata=0xABCD; busy high t+1..t+2.
- d write d_addr=0x0200, d_wdata=0x1234 -> mem_en=1, mem_we=1, mem_wdata=0x1234 in a single cycle; d_ack at t+2; rdata unchanged.
- i, d and x all requesting continuously from reset -> grant order i, d, x, i, d, x; each ack exactly one cycle, never two acks in the same cycle.
- MEM_LAT=4, x read at 0x7FFF, memory data valid 4 cycles after mem_en -> x_ack at t+5, rdata equal to the data presented at that sample; change x_addr after grant -> mem_addr stays 0x7FFF.
- Assert reset during WAIT of a d read -> all outputs 0 immediately, no d_ack; after release, i and d both requesting -> i granted first.
- With ARB_FIXED_PRIO_EN, i, d and x all requesting -> d, d, ... while d_req stays high; drop d -> x granted, then i only when x and d are both idle.
